// File: rtl/gate_exhaustive_tester_pkg.sv
// Shared definitions for the exhaustive 2-input gate tester: FSM encodings and
// truth-table constants for the standard library gates.
package gate_exhaustive_tester_pkg;

    typedef logic [1:0] gt_state_t;

    localparam gt_state_t ST_IDLE   = 2'd0;
    localparam gt_state_t ST_SETTLE = 2'd1;
    localparam gt_state_t ST_SAMPLE = 2'd2;
    localparam gt_state_t ST_DONE   = 2'd3;

    // Bit n holds the expected output for input vector {a,b} = n.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/gate_exhaustive_tester_if.sv
// Control/status bundle of the gate tester. fail_mask exists only when
// GATE_EXHAUSTIVE_TESTER_FAILMASK_EN is defined.
interface gate_exhaustive_tester_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
    logic [3:0] fail_mask;

    modport master (output start, input busy, input done, input pass, input err_cnt, input fail_mask);
    modport slave  (input start, output busy, output done, output pass, output err_cnt, output fail_mask);
`else
    modport master (output start, input busy, input done, input pass, input err_cnt);
    modport slave  (input start, output busy, output done, output pass, output err_cnt);
`endif
endinterface

// File: rtl/gate_tester_settle_cnt.sv
// 4-bit loadable down-counter with terminal-count flag, used to time how long
// each stimulus vector is held before the output is sampled.
module gate_tester_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt == 4'd0);

endmodule

// File: rtl/gate_exhaustive_tester.sv
// Exhaustive stimulus/check engine for a 2-input gate: drives 00,01,10,11, holds each
// for SETTLE_CYC cycles, samples y_i and compares against TRUTH.
// Optional fail_mask output enabled by GATE_EXHAUSTIVE_TESTER_FAILMASK_EN.
//
// state  | meaning
// IDLE   | waiting for start, outputs cleared
// SETTLE | current vector driven, waiting for gate output to settle
// SAMPLE | compare y_i with expected, advance or finish
// DONE   | result valid (done/pass/err_cnt), a_o/b_o hold 11
module gate_exhaustive_tester
    import gate_exhaustive_tester_pkg::*;
#(
    parameter logic [3:0]  TRUTH      = TT_AND,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    gate_exhaustive_tester_if.slave   bus,
    input  logic                      y_i,
    output logic                      a_o,
    output logic                      b_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    gt_state_t  state;
    logic [1:0] idx;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_cnt_r;
    logic       accept;
    logic       miss;
    logic [2:0] err_nxt;
    logic       cnt_load;
    logic       cnt_dec;
    logic       settle_tc;

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
    assign miss     = (y_i != tt_lookup(TRUTH, idx));
    assign err_nxt  = err_cnt_r + {2'b00, miss};
    // Counter reloads for the first vector and for every following vector on the sample edge.
    assign cnt_load = accept || ((state == ST_SAMPLE) && (idx != 2'd3));
    assign cnt_dec  = (state == ST_SETTLE) && !settle_tc;

    gate_tester_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .tc       (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= 3'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        idx       <= 2'd0;
                        err_cnt_r <= 3'd0;
                        done_r    <= 1'b0;
                        pass_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_cnt_r <= err_nxt;
                    if (idx == 2'd3) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (err_nxt == 3'd0);
                        state  <= ST_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
    logic [3:0] fail_mask_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_mask_r <= 4'd0;
        end else if (accept) begin
            fail_mask_r <= 4'd0;
        end else if ((state == ST_SAMPLE) && miss) begin
            fail_mask_r[idx] <= 1'b1;
        end
    end

    assign bus.fail_mask = fail_mask_r;
`endif

    assign a_o         = idx[1];
    assign b_o         = idx[0];
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Directed bench: AND tester (SETTLE_CYC=2) with selectable gate model and an
// XOR tester (SETTLE_CYC=1) with a correct XOR model.
module tb_gate_exhaustive_tester;
    import gate_exhaustive_tester_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_exhaustive_tester_if if_and ();
    gate_exhaustive_tester_if if_xor ();

    logic a_and, b_and, y_and;
    logic a_xor, b_xor, y_xor;
    int   mode;    // 0 = correct AND, 1 = tied 0, 2 = tied 1

    assign y_and = (mode == 0) ? (a_and & b_and) : (mode == 1) ? 1'b0 : 1'b1;
    assign y_xor = a_xor ^ b_xor;

    gate_exhaustive_tester #(.TRUTH(TT_AND), .SETTLE_CYC(2)) dut_and (
        .clk (clk), .rst (rst), .bus (if_and), .y_i (y_and), .a_o (a_and), .b_o (b_and)
    );

    gate_exhaustive_tester #(.TRUTH(TT_XOR), .SETTLE_CYC(1)) dut_xor (
        .clk (clk), .rst (rst), .bus (if_xor), .y_i (y_xor), .a_o (a_xor), .b_o (b_xor)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_and();
        if_and.start = 1'b1;
        tick();
        if_and.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel_xor, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((sel_xor ? if_xor.done : if_and.done) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({if_and.busy, if_and.done, if_and.pass, if_and.err_cnt, a_and, b_and} !== 8'h00) begin
            errors++;
            $display("FAIL reset_and: got %b want 00000000",
                     {if_and.busy, if_and.done, if_and.pass, if_and.err_cnt, a_and, b_and});
        end
        checks++;
        if ({if_xor.busy, if_xor.done, if_xor.pass, if_xor.err_cnt, a_xor, b_xor} !== 8'h00) begin
            errors++;
            $display("FAIL reset_xor: got %b want 00000000",
                     {if_xor.busy, if_xor.done, if_xor.pass, if_xor.err_cnt, a_xor, b_xor});
        end
`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
        checks++;
        if (if_and.fail_mask !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mask: got %b want 0000", if_and.fail_mask);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_and_correct();
        logic [1:0] exp_ab;
        mode = 0;
        pulse_start_and();
        for (int j = 0; j < 12; j++) begin
            exp_ab = 2'(j / 3);
            checks++;
            if ({a_and, b_and, if_and.busy, if_and.done} !== {exp_ab, 2'b10}) begin
                errors++;
                $display("FAIL and_seq[%0d]: got ab/busy/done %b want %b", j,
                         {a_and, b_and, if_and.busy, if_and.done}, {exp_ab, 2'b10});
            end
            tick();
        end
        checks++;
        if ({if_and.done, if_and.busy, if_and.pass, if_and.err_cnt, a_and, b_and} !== 8'b1010_0011) begin
            errors++;
            $display("FAIL and_done: got %b want 10100011",
                     {if_and.done, if_and.busy, if_and.pass, if_and.err_cnt, a_and, b_and});
        end
`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
        checks++;
        if (if_and.fail_mask !== 4'b0000) begin
            errors++;
            $display("FAIL and_mask: got %b want 0000", if_and.fail_mask);
        end
`endif
    endtask

    task automatic test_tied(input int m, input logic [2:0] exp_err, input logic [3:0] exp_mask);
        int n;
        mode = m;
        pulse_start_and();
        wait_done(1'b0, 20, n);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL tied%0d_latency: got %0d want 12", m, n);
        end
        checks++;
        if ({if_and.pass, if_and.err_cnt} !== {1'b0, exp_err}) begin
            errors++;
            $display("FAIL tied%0d_result: got pass %b err %0d want pass 0 err %0d",
                     m, if_and.pass, if_and.err_cnt, exp_err);
        end
`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
        checks++;
        if (if_and.fail_mask !== exp_mask) begin
            errors++;
            $display("FAIL tied%0d_mask: got %b want %b", m, if_and.fail_mask, exp_mask);
        end
`else
        if (exp_mask === 4'bxxxx) $display("note: unexpected mask");
`endif
    endtask

    task automatic test_xor();
        int n;
        if_xor.start = 1'b1;
        tick();
        if_xor.start = 1'b0;
        wait_done(1'b1, 20, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL xor_latency: got %0d want 8", n);
        end
        checks++;
        if ({if_xor.pass, if_xor.err_cnt, a_xor, b_xor} !== 6'b1_000_11) begin
            errors++;
            $display("FAIL xor_result: got %b want 100011", {if_xor.pass, if_xor.err_cnt, a_xor, b_xor});
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        mode = 0;
        pulse_start_and();
        repeat (6) tick();
        checks++;
        if ({a_and, b_and, if_and.busy} !== 3'b101) begin
            errors++;
            $display("FAIL midrun_pre: got ab/busy %b want 101", {a_and, b_and, if_and.busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({if_and.busy, if_and.done, if_and.pass, if_and.err_cnt, a_and, b_and} !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got %b want 00000000",
                     {if_and.busy, if_and.done, if_and.pass, if_and.err_cnt, a_and, b_and});
        end
        tick();
        checks++;
        if (if_and.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: got busy %b want 0", if_and.busy);
        end
        pulse_start_and();
        wait_done(1'b0, 20, n);
        checks++;
        if ({n, if_and.pass, if_and.err_cnt} !== {32'd12, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL midrun_rerun: got lat %0d pass %b err %0d want 12 1 0", n, if_and.pass, if_and.err_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        mode = 0;
        pulse_start_and();
        repeat (3) tick();
        if_and.start = 1'b1;
        tick();
        if_and.start = 1'b0;
        checks++;
        if ({a_and, b_and, if_and.busy} !== 3'b011) begin
            errors++;
            $display("FAIL ignore_seq: got ab/busy %b want 011", {a_and, b_and, if_and.busy});
        end
        wait_done(1'b0, 20, n);
        checks++;
        if ({n, if_and.pass} !== {32'd8, 1'b1}) begin
            errors++;
            $display("FAIL ignore_latency: got %0d pass %b want 8 pass 1", n, if_and.pass);
        end
    endtask

    task automatic test_restart_after_fail();
        int n;
        mode = 1;
        pulse_start_and();
        wait_done(1'b0, 20, n);
        checks++;
        if ({if_and.pass, if_and.err_cnt} !== 4'b0_001) begin
            errors++;
            $display("FAIL refail_result: got pass %b err %0d want 0 1", if_and.pass, if_and.err_cnt);
        end
        mode = 0;
        pulse_start_and();
        checks++;
        if ({if_and.busy, if_and.done, if_and.pass, if_and.err_cnt} !== 6'b10_0_000) begin
            errors++;
            $display("FAIL restart_accept: got %b want 100000",
                     {if_and.busy, if_and.done, if_and.pass, if_and.err_cnt});
        end
`ifdef GATE_EXHAUSTIVE_TESTER_FAILMASK_EN
        checks++;
        if (if_and.fail_mask !== 4'b0000) begin
            errors++;
            $display("FAIL restart_mask: got %b want 0000", if_and.fail_mask);
        end
`endif
        wait_done(1'b0, 20, n);
        checks++;
        if ({n, if_and.pass, if_and.err_cnt} !== {32'd12, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL restart_result: got lat %0d pass %b err %0d want 12 1 0", n, if_and.pass, if_and.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 0;
        if_and.start = 1'b1;
        tick();
        wait_done(1'b0, 20, n);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL b2b_first: got %0d want 12", n);
        end
        tick();
        if_and.start = 1'b0;
        checks++;
        if ({if_and.busy, if_and.done, a_and, b_and} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_retrigger: got busy/done/ab %b want 1000",
                     {if_and.busy, if_and.done, a_and, b_and});
        end
        wait_done(1'b0, 20, n);
        checks++;
        if ({n, if_and.pass} !== {32'd12, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second: got %0d pass %b want 12 pass 1", n, if_and.pass);
        end
    endtask

    initial begin
        rst          = 1'b1;
        mode         = 0;
        if_and.start = 1'b0;
        if_xor.start = 1'b0;
        test_reset();
        test_and_correct();
        test_tied(1, 3'd1, 4'b1000);
        test_tied(2, 3'd3, 4'b0111);
        test_xor();
        test_reset_midrun();
        test_start_ignored();
        test_restart_after_fail();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
